// File: rtl/hazard_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_ctrl_pkg
// Purpose  : Shared encodings, default timings and the register-hazard
//            compare helper for the pipeline interlock controller.
// Contents : Tuse/Tnew encodings, mult/div latency defaults, source and
//            destination descriptor structs, mult/div kind enum, reg_hit().
// Revision : 1.0 - initial release
// ============================================================================
package hazard_stall_ctrl_pkg;

  // Tuse encoding: cycles until the D instruction consumes the operand.
  localparam logic [1:0] c_TUSE_0    = 2'd0;
  localparam logic [1:0] c_TUSE_1    = 2'd1;
  localparam logic [1:0] c_TUSE_2    = 2'd2;
  localparam logic [1:0] c_TUSE_NONE = 2'd3;   // operand not read

  // Tnew encoding: cycles until the producing instruction's result exists.
  localparam logic [1:0] c_TNEW_0    = 2'd0;
  localparam logic [1:0] c_TNEW_1    = 2'd1;
  localparam logic [1:0] c_TNEW_2    = 2'd2;

  // Default mult/div occupancy, excluding the start cycle.
  localparam int c_MULT_CYCLES_DEF = 5;
  localparam int c_DIV_CYCLES_DEF  = 10;
  localparam int c_CNT_W_DEF       = 4;

  typedef struct packed {
    logic [4:0] addr;
    logic [1:0] tuse;
  } src_req_t;

  typedef struct packed {
    logic [4:0] addr;
    logic [1:0] tnew;
  } dst_req_t;

  typedef enum logic {
    MD_MULT = 1'b0,
    MD_DIV  = 1'b1
  } md_kind_e;

  // A source conflicts with an in-flight destination when the value would
  // still be unavailable by the time D needs it. $0 is hard-wired, so a
  // zero destination can never create a dependency.
  function automatic logic reg_hit(input src_req_t src, input dst_req_t dst);
    return (src.addr == dst.addr) &&
           (dst.addr != 5'd0) &&
           (src.tuse != c_TUSE_NONE) &&
           (src.tuse < dst.tnew);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_stall_ctrl_md_busy_counter.sv
`default_nettype none
// ============================================================================
// Module   : md_busy_counter
// Purpose  : Tracks occupancy of the multi-cycle mult/div unit.
// Ports    : clk          core clock
//            reset        asynchronous active-low reset
//            i_md_start   mult/div start in E this cycle
//            i_md_is_div  1 = div/divu, 0 = mult/multu
//            o_md_busy    unit occupied (start cycle included)
// Revision : 1.0 - initial release
// ============================================================================
module md_busy_counter
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = c_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = c_DIV_CYCLES_DEF,
  parameter int CNT_W       = c_CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_md_start,
  input  logic i_md_is_div,
  output logic o_md_busy
);

  localparam logic [CNT_W-1:0] c_MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] c_DIV_LOAD  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_load;
  logic             w_idle;
  md_kind_e         w_kind;

  assign w_kind = md_kind_e'(i_md_is_div);
  assign w_load = (w_kind == MD_DIV) ? c_DIV_LOAD : c_MULT_LOAD;
  assign w_idle = (r_cnt == '0);

  // A start arriving while busy is ignored; the D-stage interlock is what
  // keeps it from happening, so the running operation keeps its timing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_md_start && w_idle) begin
      r_cnt <= w_load;
    end else if (!w_idle) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // The start cycle itself already occupies the unit, hence the OR with
  // i_md_start. Reset masks it so the output is clean before any edge.
  assign o_md_busy = reset & (i_md_start | !w_idle);

endmodule
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_ctrl
// Purpose  : Pipeline interlock for the 5-stage core. Compares D-stage
//            sources (Tuse) against E/M destinations (Tnew), tracks the
//            mult/div unit and produces the PC/FD hold and DE bubble.
// Ports    : clk, reset (async active-low)
//            D_rs_addr/D_rt_addr, D_tuse_rs/D_tuse_rt, D_md_use  - D stage
//            E_dst_addr/E_tnew, M_dst_addr/M_tnew               - producers
//            E_md_start, E_md_is_div                           - mult/div
//            stall, F_PC_en, FD_en, DE_flush, md_busy          - control
//            stall_cnt                                         - perf count
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int          MULT_CYCLES    = c_MULT_CYCLES_DEF,
  parameter int          DIV_CYCLES     = c_DIV_CYCLES_DEF,
  parameter int          CNT_W          = c_CNT_W_DEF,
  parameter logic [31:0] STALL_CNT_INIT = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs_addr,
  input  logic [4:0]  D_rt_addr,
  input  logic [1:0]  D_tuse_rs,
  input  logic [1:0]  D_tuse_rt,
  input  logic        D_md_use,
  input  logic [4:0]  E_dst_addr,
  input  logic [1:0]  E_tnew,
  input  logic [4:0]  M_dst_addr,
  input  logic [1:0]  M_tnew,
  input  logic        E_md_start,
  input  logic        E_md_is_div,
  output logic        stall,
  output logic        F_PC_en,
  output logic        FD_en,
  output logic        DE_flush,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  src_req_t    w_src_rs;
  src_req_t    w_src_rt;
  dst_req_t    w_dst_e;
  dst_req_t    w_dst_m;
  logic [3:0]  w_hit;
  logic        w_md_busy;
  logic        w_md_stall;
  logic        w_stall;
  logic [31:0] r_stall_cnt;

  assign w_src_rs = '{addr: D_rs_addr, tuse: D_tuse_rs};
  assign w_src_rt = '{addr: D_rt_addr, tuse: D_tuse_rt};
  assign w_dst_e  = '{addr: E_dst_addr, tnew: E_tnew};
  assign w_dst_m  = '{addr: M_dst_addr, tnew: M_tnew};

  assign w_hit = {reg_hit(w_src_rs, w_dst_e), reg_hit(w_src_rs, w_dst_m),
                  reg_hit(w_src_rt, w_dst_e), reg_hit(w_src_rt, w_dst_m)};

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_counter (
    .clk         (clk),
    .reset       (reset),
    .i_md_start  (E_md_start),
    .i_md_is_div (E_md_is_div),
    .o_md_busy   (w_md_busy)
  );

  assign w_md_stall = D_md_use & w_md_busy;

  // Reset masks the interlock so the pipeline enables are released even
  // while the operand inputs are still undefined.
  assign w_stall = reset & ((|w_hit) | w_md_stall);

  assign stall    = w_stall;
  assign F_PC_en  = ~w_stall;
  assign FD_en    = ~w_stall;
  assign DE_flush = w_stall;
  assign md_busy  = w_md_busy;

  // Saturating perf counter: sticks at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= STALL_CNT_INIT;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_ctrl
// Purpose  : Self-checking bench for hazard_stall_ctrl: register hazard
//            vectors, mult/div occupancy, async reset and counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  D_rs_addr, D_rt_addr, E_dst_addr, M_dst_addr;
  logic [1:0]  D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
  logic        D_md_use, E_md_start, E_md_is_div;
  logic        stall, F_PC_en, FD_en, DE_flush, md_busy;
  logic [31:0] stall_cnt;
  logic        s_stall, s_F_PC_en, s_FD_en, s_DE_flush, s_md_busy;
  logic [31:0] s_stall_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  hazard_stall_ctrl dut (
    .clk(clk), .reset(reset),
    .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
    .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt), .D_md_use(D_md_use),
    .E_dst_addr(E_dst_addr), .E_tnew(E_tnew),
    .M_dst_addr(M_dst_addr), .M_tnew(M_tnew),
    .E_md_start(E_md_start), .E_md_is_div(E_md_is_div),
    .stall(stall), .F_PC_en(F_PC_en), .FD_en(FD_en), .DE_flush(DE_flush),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  // Second instance whose perf counter starts just below saturation.
  hazard_stall_ctrl #(.STALL_CNT_INIT(32'hFFFF_FFFD)) dut_sat (
    .clk(clk), .reset(reset),
    .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
    .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt), .D_md_use(D_md_use),
    .E_dst_addr(E_dst_addr), .E_tnew(E_tnew),
    .M_dst_addr(M_dst_addr), .M_tnew(M_tnew),
    .E_md_start(E_md_start), .E_md_is_div(E_md_is_div),
    .stall(s_stall), .F_PC_en(s_F_PC_en), .FD_en(s_FD_en), .DE_flush(s_DE_flush),
    .md_busy(s_md_busy), .stall_cnt(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A start while the unit is still counting must never be issued.
  always @(posedge clk) begin
    if (reset && E_md_start) begin
      assert (dut.u_md_busy_counter.r_cnt == '0)
        else $error("illegal mult/div start while busy");
    end
  end

  typedef struct {
    string      name;
    logic [4:0] rs;
    logic [1:0] tuse_rs;
    logic [4:0] rt;
    logic [1:0] tuse_rt;
    logic [4:0] e_dst;
    logic [1:0] e_tnew;
    logic [4:0] m_dst;
    logic [1:0] m_tnew;
    logic       exp_stall;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_ctrl(input string name, input logic exp_stall);
    check(name, {28'd0, stall, F_PC_en, FD_en, DE_flush},
          {28'd0, exp_stall, ~exp_stall, ~exp_stall, exp_stall});
  endtask

  task automatic idle();
    D_rs_addr = 5'd0; D_rt_addr = 5'd0; D_tuse_rs = 2'd3; D_tuse_rt = 2'd3;
    D_md_use = 1'b0; E_dst_addr = 5'd0; E_tnew = 2'd0; M_dst_addr = 5'd0;
    M_tnew = 2'd0; E_md_start = 1'b0; E_md_is_div = 1'b0;
  endtask

  // lw $1 in E feeding a beq in D: the canonical load-use interlock.
  task automatic lw_hazard();
    idle();
    D_rs_addr = 5'd1; D_tuse_rs = 2'd0; E_dst_addr = 5'd1; E_tnew = 2'd2;
  endtask

  task automatic apply(input vec_t v);
    D_rs_addr = v.rs; D_tuse_rs = v.tuse_rs; D_rt_addr = v.rt; D_tuse_rt = v.tuse_rt;
    E_dst_addr = v.e_dst; E_tnew = v.e_tnew; M_dst_addr = v.m_dst; M_tnew = v.m_tnew;
    D_md_use = 1'b0; E_md_start = 1'b0; E_md_is_div = 1'b0;
  endtask

  initial begin
    int busy_cycles;
    logic [32:0] exp_sat;

    //            name            rs tuse  rt tuse  Ed tnew Md tnew stall
    vecs[0]  = '{"lw_E_beq",      1, 0,    0, 3,    1, 2,   0, 0,   1'b1};
    vecs[1]  = '{"lw_M_tnew1",    1, 0,    0, 3,    0, 0,   1, 1,   1'b1};
    vecs[2]  = '{"lw_M_tnew0",    1, 0,    0, 3,    0, 0,   1, 0,   1'b0};
    vecs[3]  = '{"zero_reg",      0, 0,    0, 3,    0, 2,   0, 0,   1'b0};
    vecs[4]  = '{"tuse_none",     1, 3,    0, 3,    1, 2,   0, 0,   1'b0};
    vecs[5]  = '{"rt_E_t1_n2",    0, 3,    7, 1,    7, 2,   0, 0,   1'b1};
    vecs[6]  = '{"rt_E_t1_n1",    0, 3,    7, 1,    7, 1,   0, 0,   1'b0};
    vecs[7]  = '{"rt_E_t2_n2",    0, 3,    7, 2,    7, 2,   0, 0,   1'b0};
    vecs[8]  = '{"rs_M_t1_n1",    3, 1,    0, 3,    0, 0,   3, 1,   1'b0};
    vecs[9]  = '{"rs_M_t0_n1",    3, 0,    0, 3,    0, 0,   3, 1,   1'b1};
    vecs[10] = '{"addr_differ",   4, 0,    0, 3,    5, 2,   0, 0,   1'b0};
    vecs[11] = '{"rt31_M",        2, 3,   31, 0,    0, 0,  31, 1,   1'b1};

    // ---- reset held with hazards present ----
    reset = 1'b0;
    lw_hazard();
    D_md_use = 1'b1; E_md_start = 1'b1;
    #1;
    check_ctrl("reset_ctrl_t0", 1'b0);
    check("reset_md_busy_t0", {31'd0, md_busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    E_md_start = 1'b0; D_rt_addr = 5'd1; D_tuse_rt = 2'd0;
    @(negedge clk);
    check_ctrl("reset_ctrl", 1'b0);
    check("reset_stall_cnt", stall_cnt, 32'd0);
    check("reset_sat_init", s_stall_cnt, 32'hFFFF_FFFD);
    @(posedge clk); #1;
    idle();
    reset = 1'b1;

    // ---- table-driven register hazards ----
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      apply(vecs[i]);
      @(negedge clk);
      check_ctrl(vecs[i].name, vecs[i].exp_stall);
      if (vecs[i].exp_stall) exp_cnt++;
    end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    check("table_stall_cnt", stall_cnt, exp_cnt);

    // ---- mult start followed by mflo in D ----
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      idle();
      D_md_use = 1'b1;
      E_md_start = (c == 0);
      @(negedge clk);
      check_ctrl($sformatf("mult_stall_c%0d", c), c < 6);
      check($sformatf("mult_busy_c%0d", c), {31'd0, md_busy}, {31'd0, c < 6});
      if (c < 6) exp_cnt++;
    end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    check("mult_stall_cnt", stall_cnt, exp_cnt);

    // ---- div occupancy: 1 start cycle + 10 ----
    busy_cycles = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      idle();
      E_md_start = (c == 0); E_md_is_div = (c == 0);
      @(negedge clk);
      if (md_busy) busy_cycles++;
    end
    check("div_busy_cycles", busy_cycles, 32'd11);
    check("div_no_stall_cnt", stall_cnt, exp_cnt);

    // ---- div interrupted by reset at cycle 4 ----
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      idle();
      E_md_start = (c == 0); E_md_is_div = (c == 0);
      @(negedge clk);
    end
    check("div2_busy_c3", {31'd0, md_busy}, 32'd1);
    @(posedge clk); #1;
    lw_hazard();
    D_md_use = 1'b1;
    reset = 1'b0;
    #1;
    check("rst_mid_md_busy", {31'd0, md_busy}, 32'd0);
    check_ctrl("rst_mid_ctrl", 1'b0);
    check("rst_mid_stall_cnt", stall_cnt, 32'd0);
    exp_cnt = 0;
    @(posedge clk); #1;
    idle();
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_md_busy", {31'd0, md_busy}, 32'd0);
    check("post_rst_sat", s_stall_cnt, 32'hFFFF_FFFD);

    // ---- saturation of the perf counter ----
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      lw_hazard();
      @(negedge clk);
      exp_sat = 33'h0_FFFF_FFFD + 33'(k);
      if (exp_sat > 33'h0_FFFF_FFFF) exp_sat = 33'h0_FFFF_FFFF;
      check($sformatf("sat_cnt_k%0d", k), s_stall_cnt, exp_sat[31:0]);
      check($sformatf("main_cnt_k%0d", k), stall_cnt, 32'(k));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
